// File: rtl/sdram_state_ctrl_if.sv
// Host/encoder-facing signal bundle of the SDRAM state sequencer.
// Handshake: sdwr_req/sdrd_req are levels that the host raises with a stable
// length code and keeps high until its transfer starts (sdram_busy rises and
// work_state leaves W_IDLE). sdwr_ack asks for one write word per cycle and
// sdrd_ack marks one valid read word per cycle. There is no back-pressure:
// the host must accept or supply a word on every ack cycle.
interface sdram_state_ctrl_if;
  logic       sdwr_req;
  logic       sdrd_req;
  logic [8:0] sdwr_bytes;
  logic [8:0] sdrd_bytes;
  logic [3:0] init_state;
  logic [3:0] work_state;
  logic [31:0] cnt_clk;
  logic       sys_r_wn;
  logic       sdram_init_done;
  logic       sdram_busy;
  logic       sdwr_ack;
  logic       sdrd_ack;

  modport master (
    output sdwr_req, sdrd_req, sdwr_bytes, sdrd_bytes,
    input  init_state, work_state, cnt_clk, sys_r_wn,
    input  sdram_init_done, sdram_busy, sdwr_ack, sdrd_ack
  );

  modport slave (
    input  sdwr_req, sdrd_req, sdwr_bytes, sdrd_bytes,
    output init_state, work_state, cnt_clk, sys_r_wn,
    output sdram_init_done, sdram_busy, sdwr_ack, sdrd_ack
  );
endinterface

// File: rtl/sdram_state_ctrl.sv
// SDRAM command sequencer: power-up init, then refresh/write/read arbitration
// and the work FSM. State codes match the shared I_* / W_* encoding that the
// downstream command encoder decodes into SDRAM pins.
module sdram_state_ctrl #(
  parameter int T_200US    = 20000,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 7,
  parameter int T_MRD      = 2,
  parameter int T_RCD      = 2,
  parameter int CAS_LAT    = 3,
  parameter int T_DAL      = 4,
  parameter int REF_PERIOD = 750
) (
  input  logic             clk_100m,
  input  logic             rst,
  sdram_state_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    I_NOP = 4'd0, I_PRECHARGE = 4'd1, I_TRP = 4'd2, I_AUTO_REFRESH1 = 4'd3,
    I_TRF1 = 4'd4, I_AUTO_REFRESH2 = 4'd5, I_TRF2 = 4'd6, I_MRS = 4'd7,
    I_TMRD = 4'd8, I_DONE = 4'd9
  } init_t;

  typedef enum logic [3:0] {
    W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4,
    W_RD = 4'd5, W_RWAIT = 4'd6, W_WRITE = 4'd7, W_WD = 4'd8, W_TDAL = 4'd9,
    W_AR = 4'd10, W_TRFC = 4'd11
  } work_t;

  // Last cnt_clk value of each timed state (a state held N cycles leaves at N-1).
  localparam logic [31:0] NOP_LAST = 32'(T_200US - 1);
  localparam logic [31:0] RP_LAST  = 32'(T_RP - 1);
  localparam logic [31:0] RFC_LAST = 32'(T_RFC - 1);
  localparam logic [31:0] MRD_LAST = 32'(T_MRD - 1);
  localparam logic [31:0] RCD_LAST = 32'(T_RCD - 1);
  localparam logic [31:0] CL_LAST  = 32'(CAS_LAT - 2);
  localparam logic [31:0] DAL_LAST = 32'(T_DAL - 1);
  localparam logic [31:0] REF_LAST = 32'(REF_PERIOD - 1);

  init_t       init_state, init_nxt;
  work_t       work_state, work_nxt;
  logic [31:0] cnt_clk;
  logic        sys_r_wn;
  logic [8:0]  len;          // latched length code, words = len + 1
  logic        ref_flag;
  logic [31:0] ref_cnt;
  logic        init_done;
  logic        start_wr, start_rd, start_ref;
  logic        ref_wrap;

  assign init_done = (init_state == I_DONE);
  assign ref_wrap  = init_done && (ref_cnt == REF_LAST);

  // Init sequence next state; I_DONE is sticky until reset.
  always_comb begin
    init_nxt = init_state;
    case (init_state)
      I_NOP:           if (cnt_clk == NOP_LAST) init_nxt = I_PRECHARGE;
      I_PRECHARGE:     init_nxt = I_TRP;
      I_TRP:           if (cnt_clk == RP_LAST) init_nxt = I_AUTO_REFRESH1;
      I_AUTO_REFRESH1: init_nxt = I_TRF1;
      I_TRF1:          if (cnt_clk == RFC_LAST) init_nxt = I_AUTO_REFRESH2;
      I_AUTO_REFRESH2: init_nxt = I_TRF2;
      I_TRF2:          if (cnt_clk == RFC_LAST) init_nxt = I_MRS;
      I_MRS:           init_nxt = I_TMRD;
      I_TMRD:          if (cnt_clk == MRD_LAST) init_nxt = I_DONE;
      I_DONE:          init_nxt = I_DONE;
      default:         init_nxt = I_NOP;
    endcase
  end

  // Work FSM next state plus the one-cycle start strobes raised when leaving W_IDLE.
  always_comb begin
    work_nxt  = work_state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    start_ref = 1'b0;
    case (work_state)
      W_IDLE: begin
        if (init_done) begin
          if (ref_flag) begin
            work_nxt  = W_AR;
            start_ref = 1'b1;
          end else if (bus.sdwr_req) begin
            work_nxt = W_ACTIVE;
            start_wr = 1'b1;
          end else if (bus.sdrd_req) begin
            work_nxt = W_ACTIVE;
            start_rd = 1'b1;
          end
        end
      end
      W_ACTIVE: work_nxt = W_TRCD;
      W_TRCD:   if (cnt_clk == RCD_LAST) work_nxt = sys_r_wn ? W_WRITE : W_READ;
      W_WRITE:  work_nxt = (len == 9'd0) ? W_TDAL : W_WD;
      W_WD:     if (cnt_clk == {23'd0, len} - 32'd1) work_nxt = W_TDAL;
      W_READ:   work_nxt = W_CL;
      W_CL:     if (cnt_clk == CL_LAST) work_nxt = W_RD;
      W_RD:     if (cnt_clk == {23'd0, len}) work_nxt = W_TDAL;
      W_TDAL:   if (cnt_clk == DAL_LAST) work_nxt = W_IDLE;
      W_AR:     work_nxt = W_TRFC;
      W_TRFC:   if (cnt_clk == RFC_LAST) work_nxt = W_IDLE;
      default:  work_nxt = W_IDLE;
    endcase
  end

  // State registers, shared dwell counter and per-transfer direction/length latch.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      init_state <= I_NOP;
      work_state <= W_IDLE;
      cnt_clk    <= 32'd0;
      sys_r_wn   <= 1'b1;
      len        <= 9'd0;
    end else begin
      init_state <= init_nxt;
      work_state <= work_nxt;
      if ((init_nxt != init_state) || (work_nxt != work_state)) cnt_clk <= 32'd0;
      else if (cnt_clk != 32'hFFFF_FFFF) cnt_clk <= cnt_clk + 32'd1;
      if (start_wr) begin
        sys_r_wn <= 1'b1;
        len      <= bus.sdwr_bytes;
      end else if (start_rd) begin
        sys_r_wn <= 1'b0;
        len      <= bus.sdrd_bytes;
      end
    end
  end

  // Refresh timer runs once init is done; a wrap raises ref_flag, W_AR entry
  // clears it (clear wins if both happen on the same edge, so no refresh is doubled).
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      ref_cnt  <= 32'd0;
      ref_flag <= 1'b0;
    end else begin
      if (init_done) ref_cnt <= ref_wrap ? 32'd0 : ref_cnt + 32'd1;
      if (start_ref) ref_flag <= 1'b0;
      else if (ref_wrap) ref_flag <= 1'b1;
    end
  end

  assign bus.init_state      = init_state;
  assign bus.work_state      = work_state;
  assign bus.cnt_clk         = cnt_clk;
  assign bus.sys_r_wn        = sys_r_wn;
  assign bus.sdram_init_done = init_done;
  assign bus.sdram_busy      = ~init_done | (work_state != W_IDLE);
  assign bus.sdwr_ack        = (work_state == W_WRITE) || (work_state == W_WD);
  assign bus.sdrd_ack        = (work_state == W_RD);

endmodule

// File: tb/tb_sdram_state_ctrl.sv
// Bench for sdram_state_ctrl: a segment-list model (each operation is a list
// of {state, cycles}) predicts every output on every cycle; directed phases
// pin the model with hand-computed timelines, then random host traffic runs.
module tb_sdram_state_ctrl;
  localparam int T_200US = 10, T_RP = 2, T_RFC = 7, T_MRD = 2, T_RCD = 2;
  localparam int CAS_LAT = 3, T_DAL = 4, REF_PERIOD = 150;

  localparam logic [3:0] I_NOP = 4'd0, I_PRE = 4'd1, I_TRP = 4'd2, I_AR1 = 4'd3, I_TRF1 = 4'd4;
  localparam logic [3:0] I_AR2 = 4'd5, I_TRF2 = 4'd6, I_MRS = 4'd7, I_TMRD = 4'd8, I_DONE = 4'd9;
  localparam logic [3:0] W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4;
  localparam logic [3:0] W_RD = 4'd5, W_WRITE = 4'd7, W_WD = 4'd8, W_TDAL = 4'd9, W_AR = 4'd10, W_TRFC = 4'd11;

  // clock / reset
  logic clk_100m = 1'b0;
  logic rst = 1'b1;
  always #5 clk_100m = ~clk_100m;

  sdram_state_ctrl_if sif();

  sdram_state_ctrl #(
    .T_200US(T_200US), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .T_RCD(T_RCD),
    .CAS_LAT(CAS_LAT), .T_DAL(T_DAL), .REF_PERIOD(REF_PERIOD)
  ) dut (
    .clk_100m(clk_100m),
    .rst(rst),
    .bus(sif.slave)
  );

  // reference model
  typedef struct { logic [3:0] st; int rem; } seg_t;
  seg_t        init_q[$];
  seg_t        work_q[$];
  logic [31:0] m_cnt;
  logic        m_r_wn;
  logic        m_ref_flag;
  int          m_ref_age;

  // scoreboard: expected ack-burst lengths, in transfer order
  logic [9:0]  exp_q[$];
  int          ack_run;

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  bit auto_host = 1'b0;
  logic [3:0] wr_seq[12];
  logic [3:0] rd_seq[12];

  function automatic logic [3:0] m_init_st();
    return (init_q.size() > 0) ? init_q[0].st : I_DONE;
  endfunction

  function automatic logic [3:0] m_work_st();
    return (work_q.size() > 0) ? work_q[0].st : W_IDLE;
  endfunction

  task automatic push_seg(ref seg_t q[$], input logic [3:0] st, input int n);
    seg_t s;
    s.st = st;
    s.rem = n;
    if (n > 0) q.push_back(s);
  endtask

  task automatic pop_one(ref seg_t q[$]);
    seg_t s;
    s = q[0];
    s.rem = s.rem - 1;
    if (s.rem == 0) void'(q.pop_front());
    else q[0] = s;
  endtask

  task automatic model_reset();
    init_q.delete();
    work_q.delete();
    push_seg(init_q, I_NOP, T_200US); push_seg(init_q, I_PRE, 1); push_seg(init_q, I_TRP, T_RP);
    push_seg(init_q, I_AR1, 1); push_seg(init_q, I_TRF1, T_RFC); push_seg(init_q, I_AR2, 1);
    push_seg(init_q, I_TRF2, T_RFC); push_seg(init_q, I_MRS, 1); push_seg(init_q, I_TMRD, T_MRD);
    m_cnt = 32'd0;
    m_r_wn = 1'b1;
    m_ref_flag = 1'b0;
    m_ref_age = 0;
    exp_q.delete();
    ack_run = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [3:0] ci, cw;
    bit done, wrap;
    int L;
    ci = m_init_st();
    cw = m_work_st();
    done = (ci == I_DONE);
    wrap = 1'b0;
    if (done) begin
      if (m_ref_age == REF_PERIOD - 1) begin
        wrap = 1'b1;
        m_ref_age = 0;
      end else m_ref_age++;
    end
    if (init_q.size() > 0) pop_one(init_q);
    if (work_q.size() > 0) pop_one(work_q);
    else if (done) begin
      if (m_ref_flag) begin
        push_seg(work_q, W_AR, 1); push_seg(work_q, W_TRFC, T_RFC);
        m_ref_flag = 1'b0;
        wrap = 1'b0;
      end else if (sif.sdwr_req) begin
        L = int'(sif.sdwr_bytes) + 1;
        m_r_wn = 1'b1;
        push_seg(work_q, W_ACTIVE, 1); push_seg(work_q, W_TRCD, T_RCD); push_seg(work_q, W_WRITE, 1);
        push_seg(work_q, W_WD, L - 1); push_seg(work_q, W_TDAL, T_DAL);
        exp_q.push_back(10'(L));
      end else if (sif.sdrd_req) begin
        L = int'(sif.sdrd_bytes) + 1;
        m_r_wn = 1'b0;
        push_seg(work_q, W_ACTIVE, 1); push_seg(work_q, W_TRCD, T_RCD); push_seg(work_q, W_READ, 1);
        push_seg(work_q, W_CL, CAS_LAT - 1); push_seg(work_q, W_RD, L); push_seg(work_q, W_TDAL, T_DAL);
        exp_q.push_back(10'(L));
      end
    end
    if (wrap) m_ref_flag = 1'b1;
    if ((m_init_st() != ci) || (m_work_st() != cw)) m_cnt = 32'd0;
    else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", name, $time, cyc, act, exp);
    end
  endtask

  // compare process: every output against the model, every cycle
  task automatic check_cycle();
    logic [3:0] ei, ew;
    ei = m_init_st();
    ew = m_work_st();
    check("init_state", 32'(sif.init_state), 32'(ei));
    check("work_state", 32'(sif.work_state), 32'(ew));
    check("cnt_clk", sif.cnt_clk, m_cnt);
    check("sys_r_wn", 32'(sif.sys_r_wn), 32'(m_r_wn));
    check("init_done", 32'(sif.sdram_init_done), 32'(ei == I_DONE));
    check("busy", 32'(sif.sdram_busy), 32'((ei != I_DONE) || (ew != W_IDLE)));
    check("wr_ack", 32'(sif.sdwr_ack), 32'((ew == W_WRITE) || (ew == W_WD)));
    check("rd_ack", 32'(sif.sdrd_ack), 32'(ew == W_RD));
    check("ack_exclusive", 32'(sif.sdwr_ack & sif.sdrd_ack), 32'd0);
    if (sif.sdwr_ack || sif.sdrd_ack) ack_run++;
    else if (ack_run > 0) begin
      if (exp_q.size() == 0) check("ack_burst_unexpected", 32'(ack_run), 32'd0);
      else check("ack_burst_len", 32'(ack_run), 32'(exp_q.pop_front()));
      ack_run = 0;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_init_state", 32'(sif.init_state), 32'(I_NOP));
    check("rst_work_state", 32'(sif.work_state), 32'(W_IDLE));
    check("rst_cnt_clk", sif.cnt_clk, 32'd0);
    check("rst_sys_r_wn", 32'(sif.sys_r_wn), 32'd1);
    check("rst_init_done", 32'(sif.sdram_init_done), 32'd0);
    check("rst_busy", 32'(sif.sdram_busy), 32'd1);
    check("rst_acks", 32'({sif.sdwr_ack, sif.sdrd_ack}), 32'd0);
  endtask

  function automatic logic [8:0] rand_bytes();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 11) return 9'($urandom_range(0, 7));
    else if (r < 15) return 9'($urandom_range(8, 63));
    else return 9'($urandom_range(0, 511));
  endfunction

  // driver: drop a request once its transfer has started, optionally raise new ones
  task automatic host_update();
    if (m_work_st() == W_ACTIVE) begin
      if (m_r_wn) sif.sdwr_req = 1'b0;
      else sif.sdrd_req = 1'b0;
    end
    if (auto_host) begin
      if (!sif.sdwr_req && ($urandom_range(0, 15) == 0)) begin
        sif.sdwr_bytes = rand_bytes();
        sif.sdwr_req = 1'b1;
      end
      if (!sif.sdrd_req && ($urandom_range(0, 15) == 0)) begin
        sif.sdrd_bytes = rand_bytes();
        sif.sdrd_req = 1'b1;
      end
    end
  endtask

  task automatic tick();
    host_update();
    model_step();
    @(negedge clk_100m);
    cyc++;
    check_cycle();
  endtask

  task automatic wait_work(input logic [3:0] st, input int budget);
    int k;
    k = 0;
    while ((m_work_st() != st) && (k < budget)) begin
      tick();
      k++;
    end
    check("wait_work_state", 32'(sif.work_state), 32'(st));
  endtask

  task automatic release_reset();
    rst = 1'b0;
    model_reset();
    cyc = 0;
    check_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    wr_seq = '{W_ACTIVE, W_TRCD, W_TRCD, W_WRITE, W_WD, W_WD, W_WD, W_TDAL, W_TDAL, W_TDAL, W_TDAL, W_IDLE};
    rd_seq = '{W_ACTIVE, W_TRCD, W_TRCD, W_READ, W_CL, W_CL, W_RD, W_TDAL, W_TDAL, W_TDAL, W_TDAL, W_IDLE};
    sif.sdwr_req = 1'b0;
    sif.sdrd_req = 1'b0;
    sif.sdwr_bytes = 9'd0;
    sif.sdrd_bytes = 9'd0;

    // power-up reset and init timeline
    repeat (3) @(negedge clk_100m);
    check_reset_vals();
    release_reset();
    while (cyc < 32) begin
      tick();
      case (cyc)
        9:  check("lit_nop_last", 32'(sif.init_state), 32'(I_NOP));
        10: check("lit_precharge", 32'(sif.init_state), 32'(I_PRE));
        13: check("lit_ar1", 32'(sif.init_state), 32'(I_AR1));
        21: check("lit_ar2", 32'(sif.init_state), 32'(I_AR2));
        29: check("lit_mrs", 32'(sif.init_state), 32'(I_MRS));
        31: check("lit_not_done", 32'(sif.sdram_init_done), 32'd0);
        32: check("lit_done", 32'(sif.sdram_init_done), 32'd1);
        default: ;
      endcase
    end

    // write of 4 words
    sif.sdwr_bytes = 9'd3;
    sif.sdwr_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("lit_wr_state", 32'(sif.work_state), 32'(wr_seq[i]));
      check("lit_wr_ack", 32'(sif.sdwr_ack), 32'((i >= 3) && (i <= 6)));
    end
    check("lit_wr_r_wn", 32'(sif.sys_r_wn), 32'd1);

    // read of 1 word
    sif.sdrd_bytes = 9'd0;
    sif.sdrd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("lit_rd_state", 32'(sif.work_state), 32'(rd_seq[i]));
      check("lit_rd_ack", 32'(sif.sdrd_ack), 32'(i == 6));
      if (i == 1) check("lit_rd_r_wn", 32'(sif.sys_r_wn), 32'd0);
    end

    // refresh and write pending together: refresh wins
    k = 0;
    while (!m_ref_flag && (k < 1000)) begin
      tick();
      k++;
    end
    check("ref_flag_wait", 32'(k < 1000), 32'd1);
    sif.sdwr_bytes = 9'd5;
    sif.sdwr_req = 1'b1;
    tick();
    check("lit_ref_first", 32'(sif.work_state), 32'(W_AR));
    for (int i = 0; i < T_RFC; i++) begin
      tick();
      check("lit_trfc", 32'(sif.work_state), 32'(W_TRFC));
    end
    tick();
    check("lit_ref_idle", 32'(sif.work_state), 32'(W_IDLE));
    tick();
    check("lit_wr_after_ref", 32'(sif.work_state), 32'(W_ACTIVE));
    wait_work(W_IDLE, 100);

    // random host traffic
    auto_host = 1'b1;
    repeat (4000) tick();
    auto_host = 1'b0;
    sif.sdwr_req = 1'b0;
    sif.sdrd_req = 1'b0;
    wait_work(W_IDLE, 700);

    // reset in the middle of a write burst
    sif.sdwr_bytes = 9'd20;
    sif.sdwr_req = 1'b1;
    wait_work(W_WD, 50);
    repeat (3) tick();
    rst = 1'b1;
    sif.sdwr_req = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk_100m);
    check_reset_vals();
    release_reset();
    // read requested during init is held off until I_DONE
    sif.sdrd_bytes = 9'd2;
    sif.sdrd_req = 1'b1;
    while (cyc < 34) begin
      tick();
      if (cyc == 20) begin
        check("lit_init_busy", 32'(sif.sdram_busy), 32'd1);
        check("lit_init_idle", 32'(sif.work_state), 32'(W_IDLE));
      end
      if (cyc == 32) check("lit_redone", 32'(sif.sdram_init_done), 32'd1);
      if (cyc == 33) check("lit_rd_after_init", 32'(sif.work_state), 32'(W_ACTIVE));
      if (cyc == 34) check("lit_rd_after_init_rwn", 32'(sif.sys_r_wn), 32'd0);
    end
    wait_work(W_IDLE, 100);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
